// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory port arbiter.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  // Data requester
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  logic              err;

  // Memory port
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err,
    output mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err,
    input  mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one multi-cycle memory port between instruction fetch and the data stage.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIM data grants
// while fetch waits, and a timeout aborts transactions the memory never acknowledges.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_LIM = 2,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned StarveW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_if_q, owner_if_d;  // 1: fetch owns the transaction
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [3:0]          tmo_q, tmo_d;

  logic if_done, dm_done;
  logic if_req_eff, dm_req_eff;
  logic grant_if;

  // Done pulses decode straight from registered state, so they are glitch-free.
  assign if_done = (state_q == StDone) && owner_if_q;
  assign dm_done = (state_q == StDone) && !owner_if_q;

  // A requester seeing its done this cycle still holds its level request; mask it out.
  assign if_req_eff = bus.if_req && !if_done;
  assign dm_req_eff = (bus.dm_rd || bus.dm_wr) && !dm_done;

  // Next-state, grant and capture logic
  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    wr_d       = wr_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    grant_if   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req_eff || dm_req_eff) begin
          grant_if = if_req_eff && (!dm_req_eff || (starve_q == StarveW'(STARVE_LIM)));
          state_d  = StIssue;
          err_d    = 1'b0;
          if (grant_if) begin
            owner_if_d = 1'b1;
            addr_d     = bus.if_addr;
            wr_d       = 1'b0;
            starve_d   = '0;
          end else begin
            owner_if_d = 1'b0;
            addr_d     = bus.dm_addr;
            wdata_d    = bus.dm_wdata;
            wr_d       = bus.dm_wr;
            starve_d   = if_req_eff ? starve_q + StarveW'(1) : '0;
          end
        end
      end

      StIssue: begin
        tmo_d = '0;
        // An ack in the request cycle is honoured for minimum latency.
        if (bus.mem_ack) begin
          state_d = StDone;
          if (!wr_q) begin
            if (owner_if_q) if_rdata_d = bus.mem_rdata;
            else            dm_rdata_d = bus.mem_rdata;
          end
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        tmo_d = tmo_q + 4'd1;
        if (bus.mem_ack) begin
          state_d = StDone;
          if (!wr_q) begin
            if (owner_if_q) if_rdata_d = bus.mem_rdata;
            else            dm_rdata_d = bus.mem_rdata;
          end
        end else if (tmo_d == 4'(TIMEOUT)) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_if_q <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.if_done   = if_done;
  assign bus.dm_done   = dm_done;
  assign bus.err       = (state_q == StDone) && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req && !if_done;
  assign bus.dm_stall  = (bus.dm_rd || bus.dm_wr) && !dm_done;
  assign bus.mem_req   = (state_q == StIssue);
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory responder.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .STARVE_LIM(2),
    .TIMEOUT   (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents as seen by the responder.
  function automatic logic [15:0] model_rdata(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : ~a;
  endfunction

  // Responder controls (written by the main flow only)
  logic mem_en   = 1'b1;
  int   ack_dly  = 0;
  int   late_req = 0;

  // Responder state and transaction log (written by the responder only)
  int          late_done = 0;
  int          g_cnt     = 0;
  logic [15:0] g_addr  [32];
  logic        g_wr    [32];
  logic [15:0] g_wdata [32];

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (late_done != late_req) begin
        late_done++;
        bus.mem_rdata = 16'hDEAD;
        bus.mem_ack   = 1'b1;
      end else if (bus.mem_req) begin
        if (g_cnt < 32) begin
          g_addr[g_cnt]  = bus.mem_addr;
          g_wr[g_cnt]    = bus.mem_wr;
          g_wdata[g_cnt] = bus.mem_wdata;
        end
        g_cnt++;
        if (mem_en) begin
          repeat (ack_dly) @(negedge clk);
          bus.mem_rdata = model_rdata(bus.mem_addr);
          bus.mem_ack   = 1'b1;
        end
      end
    end
  end

  // Waits (bounded) for any done pulse, sampled on negedges.
  task automatic wait_done(input int max_cyc, output logic g_if, output logic g_dm,
                           output logic g_err, output int cyc);
    logic seen;
    seen  = 1'b0;
    g_if  = 1'b0;
    g_dm  = 1'b0;
    g_err = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.dm_done) begin
        seen  = 1'b1;
        g_if  = bus.if_done;
        g_dm  = bus.dm_done;
        g_err = bus.err;
        cyc   = i;
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gi, gd, ge;
    int          cyc, base, ndone;
    logic [4:0]  pat;

    bus.if_req   = 1'b0;
    bus.if_addr  = 16'h0;
    bus.dm_rd    = 1'b0;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = 16'h0;
    bus.dm_wdata = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {27'b0, bus.if_done, bus.dm_done, bus.err, bus.mem_req, bus.mem_wr}, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    rst = 1'b0;

    // Fetch-only read, ack two cycles after mem_req
    ack_dly     = 2;
    bus.if_addr = 16'h0040;
    bus.if_req  = 1'b1;
    @(negedge clk);
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_wr", bus.mem_wr, 0);
    check("t1_mem_addr", bus.mem_addr, 16'h0040);
    check("t1_stall_hi", bus.if_stall, 1);
    wait_done(20, gi, gd, ge, cyc);
    check("t1_lat", cyc, 3);
    check("t1_owner", {gi, gd}, 2'b10);
    check("t1_err", ge, 0);
    check("t1_rdata", bus.if_rdata, 16'hBEEF);
    check("t1_stall_lo", bus.if_stall, 0);
    bus.if_req = 1'b0;

    // Simultaneous fetch and data read: data first, fetch on the next idle
    @(negedge clk);
    ack_dly     = 1;
    base        = g_cnt;
    bus.if_addr = 16'h0050;
    bus.dm_addr = 16'h1000;
    bus.if_req  = 1'b1;
    bus.dm_rd   = 1'b1;
    wait_done(20, gi, gd, ge, cyc);
    check("t2_first", {gi, gd}, 2'b01);
    check("t2_lat1", cyc, 3);
    check("t2_dm_rdata", bus.dm_rdata, 16'hEFFF);
    check("t2_if_keep", bus.if_rdata, 16'hBEEF);
    bus.dm_rd = 1'b0;
    wait_done(20, gi, gd, ge, cyc);
    check("t2_second", {gi, gd}, 2'b10);
    check("t2_lat2", cyc, 4);
    check("t2_if_rdata", bus.if_rdata, 16'hFFAF);
    check("t2_order", {g_addr[base], g_addr[base+1]}, 32'h1000_0050);
    bus.if_req = 1'b0;

    // Data read to seed dm_rdata, then a write (wr wins over rd)
    @(negedge clk);
    bus.dm_addr = 16'hAAAA;
    bus.dm_rd   = 1'b1;
    wait_done(20, gi, gd, ge, cyc);
    check("t4_seed", bus.dm_rdata, 16'h5555);
    base         = g_cnt;
    bus.dm_addr  = 16'h3000;
    bus.dm_wdata = 16'h1234;
    bus.dm_wr    = 1'b1;
    wait_done(20, gi, gd, ge, cyc);
    check("t4_owner", {gi, gd}, 2'b01);
    check("t4_mem_wr", bus.mem_wr, 1);
    check("t4_mem_wdata", bus.mem_wdata, 16'h1234);
    check("t4_log", {g_wr[base], g_addr[base], g_wdata[base]}, {1'b1, 16'h3000, 16'h1234});
    check("t4_rdata_keep", bus.dm_rdata, 16'h5555);
    bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0;

    // Starvation limiter: writes held with fetch held, minimum-latency memory
    @(negedge clk);
    ack_dly      = 0;
    base         = g_cnt;
    pat          = 5'b00100;
    bus.if_addr  = 16'h0060;
    bus.dm_addr  = 16'h2000;
    bus.dm_wdata = 16'h7777;
    bus.if_req   = 1'b1;
    bus.dm_wr    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, gi, gd, ge, cyc);
      check("t3_owner", {gi, gd}, pat[k] ? 2'b10 : 2'b01);
      check("t3_lat", cyc, (k == 0) ? 2 : 3);
      check("t3_grant", g_addr[base+k], pat[k] ? 16'h0060 : 16'h2000);
    end
    bus.if_req = 1'b0;
    bus.dm_wr  = 1'b0;
    check("t3_if_rdata", bus.if_rdata, 16'hFF9F);
    check("t3_dm_keep", bus.dm_rdata, 16'h5555);

    // Timeout with no ack, then a late ack that must be ignored
    @(negedge clk);
    mem_en      = 1'b0;
    bus.if_addr = 16'h0070;
    bus.if_req  = 1'b1;
    wait_done(40, gi, gd, ge, cyc);
    check("t5_lat", cyc, 17);
    check("t5_owner", {gi, gd}, 2'b10);
    check("t5_err", ge, 1);
    check("t5_rdata_keep", bus.if_rdata, 16'hFF9F);
    bus.if_req = 1'b0;
    late_req++;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.dm_done || bus.err) ndone++;
    end
    check("t5_late_ack", ndone, 0);
    check("t5_late_rdata", bus.if_rdata, 16'hFF9F);

    // Reset in WAIT: immediate clear, no done, then normal service
    bus.dm_addr = 16'h4000;
    bus.dm_rd   = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_wait_addr", bus.mem_addr, 16'h4000);
    check("t6_stall", bus.dm_stall, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {27'b0, bus.if_done, bus.dm_done, bus.err, bus.mem_req, bus.mem_wr}, 0);
    check("t6_rst_addr", bus.mem_addr, 0);
    check("t6_rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.if_done || bus.dm_done) ndone++;
    end
    check("t6_no_done", ndone, 0);
    mem_en  = 1'b1;
    ack_dly = 1;
    rst     = 1'b0;
    wait_done(20, gi, gd, ge, cyc);
    check("t6_after_owner", {gi, gd}, 2'b01);
    check("t6_after_lat", cyc, 3);
    check("t6_after_rdata", bus.dm_rdata, 16'hBFFF);
    bus.dm_rd = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
